// File: rtl/regfile_mp.sv
// ---------------------------------------------------------------------------
// regfile_mp
//
// Multi-port general-purpose register file for the RVCPU datapath.
// NR registered read ports, two write ports (0 = ALU, 1 = load), write-first
// forwarding into the read ports, an optional hardwired-zero register 0
// (RISC-V x0 behaviour) and a per-register busy scoreboard for the issue
// stage.
//
// Parameters
//   WIDTH    register width in bits
//   DEPTH    number of registers (2..256)
//   AW       address width
//   NR       number of read ports (1..4)
//   ZERO_REG when 1, register 0 reads 0, ignores writes and is never busy
//
// Ports
//   clk                  clock, all state changes on the rising edge
//   rst_n                synchronous active-low reset
//   rd_addr   [NR*AW]    read addresses, port i at [i*AW +: AW]
//   rd_data   [NR*WIDTH] registered read data, port i at [i*WIDTH +: WIDTH]
//   rd_busy   [NR]       registered busy flag for each read address
//   wr_en0/1             write enables
//   wr_addr0/1 [AW]      write addresses
//   wr_data0/1 [WIDTH]   write data
//   busy_set             mark busy_addr as having a pending write
//   busy_addr [AW]       destination register being issued
// ---------------------------------------------------------------------------
module regfile_mp #(
  parameter int WIDTH    = 32,
  parameter int DEPTH    = 32,
  parameter int AW       = $clog2(DEPTH),
  parameter int NR       = 2,
  parameter bit ZERO_REG = 1'b1
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [NR*AW-1:0]    rd_addr,
  output logic [NR*WIDTH-1:0] rd_data,
  output logic [NR-1:0]       rd_busy,
  input  logic                wr_en0,
  input  logic [AW-1:0]       wr_addr0,
  input  logic [WIDTH-1:0]    wr_data0,
  input  logic                wr_en1,
  input  logic [AW-1:0]       wr_addr1,
  input  logic [WIDTH-1:0]    wr_data1,
  input  logic                busy_set,
  input  logic [AW-1:0]       busy_addr
);

  // One bit wider than an address so DEPTH itself is representable when
  // DEPTH is a power of two.
  localparam logic [AW:0] DEPTH_LIM = (AW+1)'(DEPTH);

  // An address names a real, writable register: inside the array and not
  // the hardwired zero register. The same rule decides whether a read
  // returns stored state or the constant 0/not-busy.
  function automatic logic addr_ok(input logic [AW-1:0] a);
    return ({1'b0, a} < DEPTH_LIM) && !(ZERO_REG && (a == '0));
  endfunction

  logic wr_ok0;
  logic wr_ok1;
  logic set_ok;

  assign wr_ok0 = wr_en0   && addr_ok(wr_addr0);
  assign wr_ok1 = wr_en1   && addr_ok(wr_addr1);
  assign set_ok = busy_set && addr_ok(busy_addr);

  logic [WIDTH-1:0] regs     [DEPTH];
  logic [WIDTH-1:0] regs_nxt [DEPTH];
  logic             busy     [DEPTH];
  logic             busy_nxt [DEPTH];

  // Per-register storage. The next-state values are also what the read
  // ports sample, which is what makes the reads write-first.
  for (genvar r = 0; r < DEPTH; r++) begin : g_reg
    localparam logic [AW-1:0] IDX = AW'(r);

    logic hit0;
    logic hit1;
    logic hit_set;

    assign hit0    = wr_ok0 && (wr_addr0  == IDX);
    assign hit1    = wr_ok1 && (wr_addr1  == IDX);
    assign hit_set = set_ok && (busy_addr == IDX);

    // Port 1 (load) beats port 0 (ALU) on an address collision.
    assign regs_nxt[r] = hit1 ? wr_data1 : (hit0 ? wr_data0 : regs[r]);

    // A retiring write clears the pending flag, but a new issue to the same
    // register in the same cycle must keep it set.
    assign busy_nxt[r] = hit_set | (busy[r] & ~(hit0 | hit1));

    always_ff @(posedge clk) begin
      if (!rst_n) begin
        regs[r] <= '0;
        busy[r] <= 1'b0;
      end else begin
        regs[r] <= regs_nxt[r];
        busy[r] <= busy_nxt[r];
      end
    end
  end

  // Read ports: each samples the post-update state of its address.
  for (genvar p = 0; p < NR; p++) begin : g_rd
    logic [AW-1:0]    addr;
    logic             ok;
    logic [AW-1:0]    idx;
    logic [WIDTH-1:0] data_q;
    logic             busy_q;

    assign addr = rd_addr[p*AW +: AW];
    assign ok   = addr_ok(addr);
    // Steer unreadable addresses to a legal index; the result is masked.
    assign idx  = ok ? addr : '0;

    always_ff @(posedge clk) begin
      if (!rst_n) begin
        data_q <= '0;
        busy_q <= 1'b0;
      end else begin
        data_q <= ok ? regs_nxt[idx] : '0;
        busy_q <= ok & busy_nxt[idx];
      end
    end

    assign rd_data[p*WIDTH +: WIDTH] = data_q;
    assign rd_busy[p]                = busy_q;
  end

endmodule

// File: tb/tb_regfile_mp.sv
// ---------------------------------------------------------------------------
// tb_regfile_mp
//
// Drives two register files from the same inputs: one with the default
// shape (32 entries, hardwired x0) and one with 24 entries and no zero
// register, so out-of-range addresses and a writable register 0 are both
// exercised. A directed vector table, a few hand sequences and a random
// phase are all compared against an array-based model of the register file.
// ---------------------------------------------------------------------------
module tb_regfile_mp;

  logic        clk;
  logic        rst_n;
  logic [9:0]  rd_addr;
  logic        wr_en0;
  logic [4:0]  wr_addr0;
  logic [31:0] wr_data0;
  logic        wr_en1;
  logic [4:0]  wr_addr1;
  logic [31:0] wr_data1;
  logic        busy_set;
  logic [4:0]  busy_addr;

  logic [63:0] rd_data_a;
  logic [1:0]  rd_busy_a;
  logic [63:0] rd_data_b;
  logic [1:0]  rd_busy_b;

  int check_count = 0;
  int pass_count  = 0;

  regfile_mp #(.WIDTH(32), .DEPTH(32), .NR(2), .ZERO_REG(1'b1)) dut (
    .clk(clk), .rst_n(rst_n),
    .rd_addr(rd_addr), .rd_data(rd_data_a), .rd_busy(rd_busy_a),
    .wr_en0(wr_en0), .wr_addr0(wr_addr0), .wr_data0(wr_data0),
    .wr_en1(wr_en1), .wr_addr1(wr_addr1), .wr_data1(wr_data1),
    .busy_set(busy_set), .busy_addr(busy_addr)
  );

  regfile_mp #(.WIDTH(32), .DEPTH(24), .NR(2), .ZERO_REG(1'b0)) dut_nz (
    .clk(clk), .rst_n(rst_n),
    .rd_addr(rd_addr), .rd_data(rd_data_b), .rd_busy(rd_busy_b),
    .wr_en0(wr_en0), .wr_addr0(wr_addr0), .wr_data0(wr_data0),
    .wr_en1(wr_en1), .wr_addr1(wr_addr1), .wr_data1(wr_data1),
    .busy_set(busy_set), .busy_addr(busy_addr)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    string       name;
    logic        rst_n;
    logic        we0;
    logic [4:0]  wa0;
    logic [31:0] wd0;
    logic        we1;
    logic [4:0]  wa1;
    logic [31:0] wd1;
    logic        bs;
    logic [4:0]  ba;
    logic [4:0]  ra0;
    logic [4:0]  ra1;
    logic [31:0] xd0;
    logic [31:0] xd1;
    logic        xb0;
    logic        xb1;
  } vec_t;

  // Reference state, index 0 = dut (zero reg, 32 deep), 1 = dut_nz (24 deep).
  logic [31:0] m_regs [2][32];
  logic        m_busy [2][32];
  logic [31:0] exp_d  [2][2];
  logic        exp_b  [2][2];

  function automatic vec_t mk(string nm, logic rst,
                              logic we0, logic [4:0] wa0, logic [31:0] wd0,
                              logic we1, logic [4:0] wa1, logic [31:0] wd1,
                              logic bs, logic [4:0] ba,
                              logic [4:0] ra0, logic [4:0] ra1,
                              logic [31:0] xd0, logic [31:0] xd1,
                              logic xb0, logic xb1);
    vec_t v;
    v.name = nm; v.rst_n = rst;
    v.we0 = we0; v.wa0 = wa0; v.wd0 = wd0;
    v.we1 = we1; v.wa1 = wa1; v.wd1 = wd1;
    v.bs = bs; v.ba = ba; v.ra0 = ra0; v.ra1 = ra1;
    v.xd0 = xd0; v.xd1 = xd1; v.xb0 = xb0; v.xb1 = xb1;
    return v;
  endfunction

  // Whether an address refers to a real, non-zero-hardwired register.
  function automatic bit usable(int inst, logic [4:0] a);
    int ai;
    ai = int'(a);
    if (inst == 0) return (ai < 32) && (ai != 0);
    return ai < 24;
  endfunction

  // Advance the model one clock with the given inputs, then derive what
  // each read port must show afterwards.
  task automatic modelStep(input vec_t v);
    logic [4:0] a;
    for (int inst = 0; inst < 2; inst++) begin
      if (!v.rst_n) begin
        for (int r = 0; r < 32; r++) begin
          m_regs[inst][r] = '0;
          m_busy[inst][r] = 1'b0;
        end
      end else begin
        if (v.we0 && usable(inst, v.wa0)) begin
          m_regs[inst][v.wa0] = v.wd0;
          m_busy[inst][v.wa0] = 1'b0;
        end
        if (v.we1 && usable(inst, v.wa1)) begin
          m_regs[inst][v.wa1] = v.wd1;
          m_busy[inst][v.wa1] = 1'b0;
        end
        if (v.bs && usable(inst, v.ba)) m_busy[inst][v.ba] = 1'b1;
      end
      for (int p = 0; p < 2; p++) begin
        a = (p == 0) ? v.ra0 : v.ra1;
        if (v.rst_n && usable(inst, a)) begin
          exp_d[inst][p] = m_regs[inst][a];
          exp_b[inst][p] = m_busy[inst][a];
        end else begin
          exp_d[inst][p] = '0;
          exp_b[inst][p] = 1'b0;
        end
      end
    end
  endtask

  task automatic applyStimulus(input vec_t v);
    rst_n     = v.rst_n;
    wr_en0    = v.we0;
    wr_addr0  = v.wa0;
    wr_data0  = v.wd0;
    wr_en1    = v.we1;
    wr_addr1  = v.wa1;
    wr_data1  = v.wd1;
    busy_set  = v.bs;
    busy_addr = v.ba;
    rd_addr   = {v.ra1, v.ra0};
    modelStep(v);
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string name, input logic [31:0] act,
                             input logic [31:0] req);
    check_count++;
    if (act === req) pass_count++;
    else $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, act, req);
  endtask

  // Compare every port of both instances against the model.
  task automatic checkModel(input string tag);
    for (int p = 0; p < 2; p++) begin
      checkOutput($sformatf("%s_a_data%0d", tag, p), rd_data_a[p*32 +: 32], exp_d[0][p]);
      checkOutput($sformatf("%s_a_busy%0d", tag, p), 32'(rd_busy_a[p]), 32'(exp_b[0][p]));
      checkOutput($sformatf("%s_b_data%0d", tag, p), rd_data_b[p*32 +: 32], exp_d[1][p]);
      checkOutput($sformatf("%s_b_busy%0d", tag, p), 32'(rd_busy_b[p]), 32'(exp_b[1][p]));
    end
  endtask

  vec_t tbl[$];
  vec_t rv;

  initial begin
    rst_n = 1'b0; rd_addr = '0;
    wr_en0 = 1'b0; wr_addr0 = '0; wr_data0 = '0;
    wr_en1 = 1'b0; wr_addr1 = '0; wr_data1 = '0;
    busy_set = 1'b0; busy_addr = '0;

    // Expected values below are for the zero-register instance.
    tbl.push_back(mk("rst0", 0, 0,0,0, 0,0,0, 0,0, 0,0, 0,0, 0,0));
    tbl.push_back(mk("rst1", 0, 1,5,32'h1234, 1,6,32'h5678, 1,5, 5,6, 0,0, 0,0));
    for (int i = 0; i < 32; i++)
      tbl.push_back(mk($sformatf("sweep%0d", i), 1, 0,0,0, 0,0,0, 0,0,
                       5'(i), 5'(31 - i), 0,0, 0,0));
    tbl.push_back(mk("bypass",      1, 1,5,32'hDEADBEEF, 0,0,0, 0,0, 5,5, 32'hDEADBEEF,32'hDEADBEEF, 0,0));
    tbl.push_back(mk("bypass_arr",  1, 0,0,0, 0,0,0, 0,0, 5,0, 32'hDEADBEEF,0, 0,0));
    tbl.push_back(mk("collide",     1, 1,7,32'h11, 1,7,32'h22, 0,0, 5,7, 32'hDEADBEEF,32'h22, 0,0));
    tbl.push_back(mk("collide_arr", 1, 0,0,0, 0,0,0, 0,0, 7,7, 32'h22,32'h22, 0,0));
    tbl.push_back(mk("race_set",    1, 0,0,0, 0,0,0, 1,3, 3,3, 0,0, 1,1));
    tbl.push_back(mk("race_hold",   1, 0,0,0, 0,0,0, 0,0, 3,7, 0,32'h22, 1,0));
    tbl.push_back(mk("race_both",   1, 0,0,0, 1,3,32'h33, 1,3, 3,3, 32'h33,32'h33, 1,1));
    tbl.push_back(mk("race_keep",   1, 0,0,0, 0,0,0, 0,0, 3,3, 32'h33,32'h33, 1,1));
    tbl.push_back(mk("race_clear",  1, 1,3,32'h44, 0,0,0, 0,0, 3,3, 32'h44,32'h44, 0,0));
    tbl.push_back(mk("race_after",  1, 0,0,0, 0,0,0, 0,0, 3,3, 32'h44,32'h44, 0,0));
    tbl.push_back(mk("fill_a",      1, 1,1,32'h101, 1,2,32'h202, 0,0, 1,2, 32'h101,32'h202, 0,0));
    tbl.push_back(mk("fill_b",      1, 1,3,32'h303, 1,4,32'h404, 1,2, 2,4, 32'h202,32'h404, 1,0));
    tbl.push_back(mk("fill_chk",    1, 0,0,0, 0,0,0, 0,0, 2,3, 32'h202,32'h303, 1,0));
    tbl.push_back(mk("mid_rst",     0, 1,4,32'h999, 0,0,0, 1,1, 4,2, 0,0, 0,0));
    tbl.push_back(mk("post_rst_a",  1, 0,0,0, 0,0,0, 0,0, 4,2, 0,0, 0,0));
    tbl.push_back(mk("post_rst_b",  1, 0,0,0, 0,0,0, 0,0, 1,3, 0,0, 0,0));

    foreach (tbl[i]) begin
      applyStimulus(tbl[i]);
      checkOutput({tbl[i].name, "_d0"}, rd_data_a[31:0],  tbl[i].xd0);
      checkOutput({tbl[i].name, "_d1"}, rd_data_a[63:32], tbl[i].xd1);
      checkOutput({tbl[i].name, "_b0"}, 32'(rd_busy_a[0]), 32'(tbl[i].xb0));
      checkOutput({tbl[i].name, "_b1"}, 32'(rd_busy_a[1]), 32'(tbl[i].xb1));
      checkModel(tbl[i].name);
    end

    // Register 0: hardwired on dut, an ordinary register on dut_nz.
    applyStimulus(mk("zr_wr", 1, 1,0,32'hFFFFFFFF, 0,0,0, 1,0, 0,0, 0,0, 0,0));
    checkOutput("zr_wr_a_data", rd_data_a[31:0], 32'h0);
    checkOutput("zr_wr_a_busy", 32'(rd_busy_a[0]), 32'h0);
    checkOutput("zr_wr_b_data", rd_data_b[31:0], 32'hFFFFFFFF);
    checkOutput("zr_wr_b_busy", 32'(rd_busy_b[0]), 32'h1);
    checkModel("zr_wr");
    applyStimulus(mk("zr_rd", 1, 0,0,0, 0,0,0, 0,0, 0,0, 0,0, 0,0));
    checkOutput("zr_rd_a_data", rd_data_a[63:32], 32'h0);
    checkOutput("zr_rd_b_data", rd_data_b[63:32], 32'hFFFFFFFF);
    checkOutput("zr_rd_b_busy", 32'(rd_busy_b[1]), 32'h1);
    checkModel("zr_rd");

    // Addresses past the end of the 24-deep instance are dropped and read 0.
    applyStimulus(mk("oor_wr", 1, 0,0,0, 1,28,32'hABCD0123, 1,29, 28,29, 0,0, 0,0));
    checkOutput("oor_wr_a_data", rd_data_a[31:0], 32'hABCD0123);
    checkOutput("oor_wr_b_data", rd_data_b[31:0], 32'h0);
    checkOutput("oor_wr_a_busy", 32'(rd_busy_a[1]), 32'h1);
    checkOutput("oor_wr_b_busy", 32'(rd_busy_b[1]), 32'h0);
    checkModel("oor_wr");

    // Busy set on port-0 write address in the same cycle: the set wins.
    applyStimulus(mk("set_vs_wr0", 1, 1,9,32'h99, 0,0,0, 1,9, 9,9, 0,0, 0,0));
    checkOutput("set_vs_wr0_data", rd_data_a[31:0], 32'h99);
    checkOutput("set_vs_wr0_busy", 32'(rd_busy_a[0]), 32'h1);
    checkModel("set_vs_wr0");

    // Random traffic with occasional reset.
    for (int n = 0; n < 600; n++) begin
      rv = mk("rnd", ($urandom_range(63) != 0),
              1'($urandom_range(1)), 5'($urandom_range(31)), $urandom,
              1'($urandom_range(1)), 5'($urandom_range(31)), $urandom,
              ($urandom_range(3) == 0), 5'($urandom_range(31)),
              5'($urandom_range(31)), 5'($urandom_range(31)),
              0, 0, 0, 0);
      if (n % 4 == 1) rv.ra0 = rv.wa0;
      if (n % 4 == 2) rv.ra1 = rv.ba;
      if (n % 8 == 3) rv.wa1 = rv.wa0;
      applyStimulus(rv);
      checkModel($sformatf("rnd%0d", n));
    end

    $display("%0d/%0d checks passed", pass_count, check_count);
    $finish;
  end

endmodule
